// File: rtl/periph_pkg.sv
// Shared constants and types for the memory-mapped peripherals on the data bus.
package periph_pkg;

    typedef logic [31:0] word_t;

    localparam word_t TIMER_BASE  = 32'h4000_0000;

    localparam word_t OFF_TH      = 32'h0000_0000;
    localparam word_t OFF_TL      = 32'h0000_0004;
    localparam word_t OFF_TCON    = 32'h0000_0008;
    localparam word_t OFF_CNT     = 32'h0000_000C;
    localparam word_t OFF_SYSTICK = 32'h0000_0010;

    localparam int TCON_RUN = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_ST  = 2;

endpackage

// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer raising irq on counter overflow.
// Define TIMER_SYSTICK_EN to add a free-running read-only SYSTICK at +0x10.
module timer_irq_source
    import periph_pkg::*;
#(
    parameter word_t BASE_ADDR = TIMER_BASE,
    parameter int    TCON_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        in_kernel,
    output logic        irq
);

    word_t              th;
    word_t              tl;
    word_t              cnt;
    logic [TCON_W-1:0]  tcon;
    logic [TCON_W-1:0]  tcon_nxt;

    word_t off;
    word_t word_idx;
    logic  sel_th;
    logic  sel_tl;
    logic  sel_tcon;
    logic  sel_cnt;
    logic  overflow;

    // Byte offsets are reduced to word indices so addr[1:0] never affects decode.
    always_comb begin
        off      = addr - BASE_ADDR;
        word_idx = off >> 2;
        sel_th   = (word_idx == (OFF_TH   >> 2));
        sel_tl   = (word_idx == (OFF_TL   >> 2));
        sel_tcon = (word_idx == (OFF_TCON >> 2));
        sel_cnt  = (word_idx == (OFF_CNT  >> 2));
    end

    assign overflow = tcon[TCON_RUN] && (tl == '1);

    // A bus write to TCON overrides the status set by a coincident overflow.
    always_comb begin
        tcon_nxt = tcon;
        if (wr && sel_tcon) begin
            tcon_nxt = wdata[TCON_W-1:0];
        end else if (overflow && tcon[TCON_IE]) begin
            tcon_nxt[TCON_ST] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            cnt  <= '0;
            tcon <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr && sel_th) begin
                th <= wdata;
            end

            if (wr && sel_tl) begin
                tl <= wdata;
            end else if (tcon[TCON_RUN]) begin
                tl <= overflow ? th : tl + 32'd1;
            end

            if (overflow) begin
                cnt <= cnt + 32'd1;
            end

            tcon <= tcon_nxt;
            irq  <= tcon[TCON_IE] & tcon[TCON_ST] & ~in_kernel;
        end
    end

`ifdef TIMER_SYSTICK_EN
    word_t systick;
    logic  sel_systick;

    assign sel_systick = (word_idx == (OFF_SYSTICK >> 2));

    always_ff @(posedge clk) begin
        if (reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_th) begin
                rdata = th;
            end else if (sel_tl) begin
                rdata = tl;
            end else if (sel_tcon) begin
                rdata = {{(32-TCON_W){1'b0}}, tcon};
            end else if (sel_cnt) begin
                rdata = cnt;
            end
`ifdef TIMER_SYSTICK_EN
            else if (sel_systick) begin
                rdata = systick;
            end
`endif
        end
    end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed checks of the timer register map, overflow/irq timing and corner cases.
module tb_timer_irq_source;

    localparam logic [31:0] B     = 32'h4000_0000;
    localparam logic [31:0] A_TH  = B + 32'h00;
    localparam logic [31:0] A_TL  = B + 32'h04;
    localparam logic [31:0] A_TC  = B + 32'h08;
    localparam logic [31:0] A_CNT = B + 32'h0C;
    localparam logic [31:0] A_ST  = B + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        in_kernel;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    timer_irq_source #(.BASE_ADDR(B), .TCON_W(3)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .in_kernel(in_kernel), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        tick();
        wr = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        rd = 1'b1; addr = a;
        #1;
        check(name, rdata, exp);
        rd = 1'b0; addr = '0;
    endtask

    logic [31:0] st0;
    logic [31:0] st1;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, A_TH,          32'hA5A5_0001, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, A_TH,          32'h0,         32'hA5A5_0001};
        vecs[2]  = '{1'b1, 1'b1, A_TH,          32'h1111_2222, 32'hA5A5_0001};
        vecs[3]  = '{1'b0, 1'b1, A_TH,          32'h0,         32'h1111_2222};
        vecs[4]  = '{1'b1, 1'b0, A_TL,          32'h0000_1234, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, B + 32'h7,     32'h0,         32'h0000_1234};
        vecs[6]  = '{1'b1, 1'b0, A_CNT,         32'hDEAD_BEEF, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, A_CNT,         32'h0,         32'h0};
        vecs[8]  = '{1'b1, 1'b0, B + 32'h14,    32'h5,         32'h0};
        vecs[9]  = '{1'b0, 1'b1, B + 32'h14,    32'h0,         32'h0};
        vecs[10] = '{1'b0, 1'b1, B + 32'h100,   32'h0,         32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h3FFF_FFFC, 32'h0,         32'h0};
        vecs[12] = '{1'b1, 1'b0, A_TC,          32'hFFFF_FFFC, 32'h0};
        vecs[13] = '{1'b0, 1'b1, A_TC,          32'h0,         32'h4};
        vecs[14] = '{1'b1, 1'b0, A_TC,          32'h0,         32'h0};
        vecs[15] = '{1'b0, 1'b1, A_TC,          32'h0,         32'h0};

        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; in_kernel = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_irq", {31'b0, irq}, 32'h0);
        read_chk("reset_tcon", A_TC, 32'h0);

        for (int i = 0; i < 16; i++) begin
            wr = vecs[i].wr; rd = vecs[i].rd; addr = vecs[i].addr; wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
            tick();
            wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
        end
        check("vec_irq", {31'b0, irq}, 32'h0);

        // Reset mid-count, coinciding with a bus write, wins.
        bus_write(A_TL, 32'h0000_1234);
        bus_write(A_TC, 32'h7);
        reset = 1'b1; wr = 1'b1; addr = A_TC; wdata = 32'h7;
        tick();
        reset = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        read_chk("rst_tl", A_TL, 32'h0);
        read_chk("rst_th", A_TH, 32'h0);
        read_chk("rst_tcon", A_TC, 32'h0);
        read_chk("rst_cnt", A_CNT, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Overflow timing: reload, status at 4th edge, irq at 5th.
        bus_write(A_TH, 32'hFFFF_FFFC);
        bus_write(A_TL, 32'hFFFF_FFFC);
        bus_write(A_TC, 32'h3);
        tick(); tick(); tick();
        read_chk("ov_tl_max", A_TL, 32'hFFFF_FFFF);
        tick();
        read_chk("ov_tl_reload", A_TL, 32'hFFFF_FFFC);
        read_chk("ov_tcon", A_TC, 32'h7);
        read_chk("ov_cnt", A_CNT, 32'h1);
        check("ov_irq_lat0", {31'b0, irq}, 32'h0);
        tick();
        check("ov_irq", {31'b0, irq}, 32'h1);

        // Software clear and re-raise.
        bus_write(A_TC, 32'h3);
        check("clr_irq_same", {31'b0, irq}, 32'h1);
        tick();
        check("clr_irq_drop", {31'b0, irq}, 32'h0);
        tick();
        check("clr_irq_low", {31'b0, irq}, 32'h0);
        tick();
        check("rerise_irq", {31'b0, irq}, 32'h1);
        read_chk("rerise_cnt", A_CNT, 32'h2);

        // Write TCON on the overflow cycle: write wins, TL reloads, CNT increments.
        bus_write(A_TC, 32'h3);
        bus_write(A_TL, 32'hFFFF_FFFE);
        tick();
        bus_write(A_TC, 32'h1);
        read_chk("wov_tcon", A_TC, 32'h1);
        read_chk("wov_tl", A_TL, 32'hFFFF_FFFC);
        read_chk("wov_cnt", A_CNT, 32'h3);
        bus_write(A_TC, 32'h0);
        check("wov_irq", {31'b0, irq}, 32'h0);

        // Kernel mode masks irq while status is set.
        bus_write(A_TL, 32'hFFFF_FFFF);
        in_kernel = 1'b1;
        bus_write(A_TC, 32'h3);
        tick();
        read_chk("kern_tcon", A_TC, 32'h7);
        read_chk("kern_cnt", A_CNT, 32'h4);
        tick();
        check("kern_irq_masked", {31'b0, irq}, 32'h0);
        in_kernel = 1'b0;
        tick();
        check("kern_irq_unmask", {31'b0, irq}, 32'h1);

        // Write TL on the overflow cycle: write wins, status still set.
        bus_write(A_TC, 32'h0);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TC, 32'h3);
        bus_write(A_TL, 32'h0000_0100);
        read_chk("wtl_tl", A_TL, 32'h0000_0100);
        read_chk("wtl_tcon", A_TC, 32'h7);
        read_chk("wtl_cnt", A_CNT, 32'h5);
        bus_write(A_TC, 32'h0);

        // CNT is read-only.
        bus_write(A_CNT, 32'h0000_0000);
        read_chk("cnt_ro", A_CNT, 32'h5);

        // SYSTICK delta over five cycles.
        rd = 1'b1; addr = A_ST; #1; st0 = rdata; rd = 1'b0; addr = '0;
        for (int i = 0; i < 5; i++) tick();
        rd = 1'b1; addr = A_ST; #1; st1 = rdata; rd = 1'b0; addr = '0;
`ifdef TIMER_SYSTICK_EN
        check("systick_delta", st1 - st0, 32'd5);
`else
        check("systick_absent0", st0, 32'h0);
        check("systick_absent1", st1, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
